// File: rtl/bcd_display_scanner_pkg.sv
// Shared types and constants for the two-digit BCD display scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package bcd_display_scanner_pkg;

    typedef enum logic [1:0] {
        BLANK_T = 2'd0,
        SHOW_T  = 2'd1,
        BLANK_O = 2'd2,
        SHOW_O  = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [1:0] AN_OFF  = 2'b11;
    localparam logic [1:0] AN_TENS = 2'b10;
    localparam logic [1:0] AN_ONES = 2'b01;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    function automatic logic digit_invalid(input logic [3:0] digit);
        return (digit > 4'd9);
    endfunction

endpackage

// File: rtl/bcd_display_scanner_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10..15 are shown as 'E' so a bad digit is visible on the panel.
module bcd_to_seg7
    import bcd_display_scanner_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Digit pattern lookup
    always_comb begin
        seg = SEG_E;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Captures a BCD digit pair over valid/ready and scans it onto a two-digit
// common-anode display, committing new digits only at frame boundaries.
module bcd_display_scanner
    import bcd_display_scanner_pkg::*;
#(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 8
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_val,
    output logic       in_rdy,
    input  logic [3:0] in_tens,
    input  logic [3:0] in_ones,
    input  logic       lz_blank_en,
    output logic [1:0] an,
    output logic [6:0] seg,
    output logic       err
);

    localparam int MAX_LEN = (REFRESH_DIV > BLANK_CYCLES) ?
                             ((REFRESH_DIV > 2) ? REFRESH_DIV : 2) :
                             ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
    localparam int CNT_W = $clog2(MAX_LEN);

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    // With no blanking the reset-time BLANK_T still occupies a single cycle.
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

    scan_state_t      state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s, state_last_s;
    logic             done_s;
    logic [3:0]       disp_tens_r, disp_ones_r;
    logic [3:0]       disp_tens_next_s, disp_ones_next_s;
    logic [7:0]       shadow_r;
    logic             pending_r;
    logic             capture_s, commit_s;
    logic [3:0]       digit_sel_s;
    logic [6:0]       seg_dec_s;
    logic [1:0]       an_r, an_next_s;
    logic [6:0]       seg_r, seg_next_s;
    logic             err_r, err_next_s;

    assign in_rdy = ~pending_r;
    assign an     = an_r;
    assign seg    = seg_r;
    assign err    = err_r;

    // Slot length, next state and counter sequencing
    always_comb begin
        state_next_s = state_r;
        state_last_s = BLANK_LAST;
        if ((state_r == SHOW_T) || (state_r == SHOW_O)) begin
            state_last_s = SHOW_LAST;
        end else begin
            state_last_s = BLANK_LAST;
        end
        done_s = (cnt_r == state_last_s);
        if (done_s) begin
            cnt_next_s = CNT_ZERO;
            case (state_r)
                BLANK_T: state_next_s = SHOW_T;
                SHOW_T:  state_next_s = (BLANK_CYCLES == 0) ? SHOW_O : BLANK_O;
                BLANK_O: state_next_s = SHOW_O;
                SHOW_O:  state_next_s = (BLANK_CYCLES == 0) ? SHOW_T : BLANK_T;
                default: state_next_s = BLANK_T;
            endcase
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
        end
    end

    // Handshake capture and frame-boundary commit
    always_comb begin
        capture_s = in_val & ~pending_r;
        commit_s  = (state_r == SHOW_O) & done_s & pending_r;
        if (commit_s) begin
            disp_tens_next_s = shadow_r[7:4];
            disp_ones_next_s = shadow_r[3:0];
            err_next_s       = digit_invalid(shadow_r[7:4]) | digit_invalid(shadow_r[3:0]);
        end else begin
            disp_tens_next_s = disp_tens_r;
            disp_ones_next_s = disp_ones_r;
            err_next_s       = err_r;
        end
    end

    // Digit routed to the shared decoder follows the upcoming slot
    always_comb begin
        if (state_next_s == SHOW_T) begin
            digit_sel_s = disp_tens_next_s;
        end else begin
            digit_sel_s = disp_ones_next_s;
        end
    end

    bcd_to_seg7 u_dec (
        .digit (digit_sel_s),
        .seg   (seg_dec_s)
    );

    // Anode/segment values for the upcoming slot, including leading-zero blanking
    always_comb begin
        an_next_s  = AN_OFF;
        seg_next_s = SEG_OFF;
        case (state_next_s)
            SHOW_T: begin
                if (lz_blank_en && (disp_tens_next_s == 4'd0)) begin
                    an_next_s  = AN_OFF;
                    seg_next_s = SEG_OFF;
                end else begin
                    an_next_s  = AN_TENS;
                    seg_next_s = seg_dec_s;
                end
            end
            SHOW_O: begin
                an_next_s  = AN_ONES;
                seg_next_s = seg_dec_s;
            end
            default: begin
                an_next_s  = AN_OFF;
                seg_next_s = SEG_OFF;
            end
        endcase
    end

    // Scan state and slot counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= BLANK_T;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Shadow/pending handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r  <= 8'h00;
            pending_r <= 1'b0;
        end else if (capture_s) begin
            shadow_r  <= {in_tens, in_ones};
            pending_r <= 1'b1;
        end else if (commit_s) begin
            pending_r <= 1'b0;
        end
    end

    // Committed digits, error flag and display drive registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_tens_r <= 4'd0;
            disp_ones_r <= 4'd0;
            err_r       <= 1'b0;
            an_r        <= AN_OFF;
            seg_r       <= SEG_OFF;
        end else begin
            disp_tens_r <= disp_tens_next_s;
            disp_ones_r <= disp_ones_next_s;
            err_r       <= err_next_s;
            an_r        <= an_next_s;
            seg_r       <= seg_next_s;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomised bench for bcd_display_scanner with a frame-position reference
// model; instance a uses 2 blank cycles, instance b uses none.
module tb_bcd_display_scanner;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_val = 1'b0;
    logic [3:0] in_tens = 4'd0;
    logic [3:0] in_ones = 4'd0;
    logic       lz_blank_en = 1'b0;

    logic       in_rdy_a, err_a, in_rdy_b, err_b;
    logic [1:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = instance a, 1 = instance b
    int unsigned mp    [2];
    bit          mpend [2];
    logic [3:0]  msh_t [2];
    logic [3:0]  msh_o [2];
    logic [3:0]  mdt   [2];
    logic [3:0]  mdo   [2];
    bit          merr  [2];
    logic [1:0]  exp_an  [2];
    logic [6:0]  exp_seg [2];
    int          blk   [2] = '{2, 0};

    always #5 clk = ~clk;

    bcd_display_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy_a),
        .in_tens(in_tens), .in_ones(in_ones), .lz_blank_en(lz_blank_en),
        .an(an_a), .seg(seg_a), .err(err_a)
    );

    bcd_display_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy_b),
        .in_tens(in_tens), .in_ones(in_ones), .lz_blank_en(lz_blank_en),
        .an(an_b), .seg(seg_b), .err(err_b)
    );

    function automatic logic [6:0] exp_dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h06;
        endcase
    endfunction

    // 0=BLANK_T 1=SHOW_T 2=BLANK_O 3=SHOW_O for cycle p counted from reset release
    function automatic int phase_of(input int bl, input int unsigned p);
        int unsigned m;
        if (bl == 0) begin
            if (p == 0) return 0;
            m = (p - 1) % (2 * R);
            return (m < R) ? 1 : 3;
        end
        m = p % (2 * (bl + R));
        if (m < bl) return 0;
        if (m < bl + R) return 1;
        if (m < 2 * bl + R) return 2;
        return 3;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: frame position, handshake, commit and expected outputs
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mp[i] = 0; mpend[i] = 0; msh_t[i] = 0; msh_o[i] = 0;
                mdt[i] = 0; mdo[i] = 0; merr[i] = 0;
                exp_an[i] = 2'b11; exp_seg[i] = 7'h7F;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit commit, cap;
                int ph;
                commit = (phase_of(blk[i], mp[i]) == 3) && (phase_of(blk[i], mp[i] + 1) != 3) && mpend[i];
                cap    = in_val && !mpend[i];
                if (commit) begin
                    mdt[i] = msh_t[i]; mdo[i] = msh_o[i];
                    merr[i] = (msh_t[i] > 9) || (msh_o[i] > 9);
                    mpend[i] = 0;
                end
                if (cap) begin
                    msh_t[i] = in_tens; msh_o[i] = in_ones; mpend[i] = 1;
                end
                mp[i]++;
                ph = phase_of(blk[i], mp[i]);
                exp_an[i] = 2'b11; exp_seg[i] = 7'h7F;
                if (ph == 1 && !(lz_blank_en && mdt[i] == 0)) begin
                    exp_an[i] = 2'b10; exp_seg[i] = exp_dec(mdt[i]);
                end else if (ph == 3) begin
                    exp_an[i] = 2'b01; exp_seg[i] = exp_dec(mdo[i]);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("an_a",  {6'd0, an_a},   {6'd0, exp_an[0]});
        chk("seg_a", {1'b0, seg_a},  {1'b0, exp_seg[0]});
        chk("err_a", {7'd0, err_a},  {7'd0, merr[0]});
        chk("rdy_a", {7'd0, in_rdy_a}, {7'd0, !mpend[0]});
        chk("an_b",  {6'd0, an_b},   {6'd0, exp_an[1]});
        chk("seg_b", {1'b0, seg_b},  {1'b0, exp_seg[1]});
        chk("err_b", {7'd0, err_b},  {7'd0, merr[1]});
        chk("rdy_b", {7'd0, in_rdy_b}, {7'd0, !mpend[1]});
    end

    task automatic wait_p(input int unsigned t);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (mp[0] != t && n < 200);
        chk("wait_p_timeout", {7'd0, (mp[0] == t)}, 8'd1);
    endtask

    task automatic lit(input string nm, input logic [1:0] a, input logic [6:0] s);
        @(negedge clk); #1;
        chk({nm, "_an"},  {6'd0, an_a}, {6'd0, a});
        chk({nm, "_seg"}, {1'b0, seg_a}, {1'b0, s});
    endtask

    task automatic set_in(input logic v, input logic [3:0] t, input logic [3:0] o);
        in_val = v; in_tens = t; in_ones = o;
    endtask

    // Mid-cycle asynchronous reset: outputs must clear without a clock edge
    task automatic async_reset_check();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_an_a",  {6'd0, an_a}, 8'h03);
        chk("rst_seg_a", {1'b0, seg_a}, 8'h7F);
        chk("rst_err_a", {7'd0, err_a}, 8'h00);
        chk("rst_rdy_a", {7'd0, in_rdy_a}, 8'h01);
        chk("rst_an_b",  {6'd0, an_b}, 8'h03);
        chk("rst_rdy_b", {7'd0, in_rdy_b}, 8'h01);
        chk("rst_err_b", {7'd0, err_b}, 8'h00);
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_p(5);
        async_reset_check();

        // First SHOW_T two cycles after release shows 0
        wait_p(2);
        lit("first_show", 2'b10, 7'h40);
        set_in(1'b1, 4'd2, 4'd7);
        wait_p(3);
        set_in(1'b0, 4'd0, 4'd0);
        @(negedge clk); #1 chk("rdy_after_cap", {7'd0, in_rdy_a}, 8'h00);
        // Offer while pending must be ignored
        wait_p(4);
        set_in(1'b1, 4'd5, 4'd5);
        wait_p(5);
        set_in(1'b0, 4'd0, 4'd0);
        wait_p(14); lit("tens_27", 2'b10, 7'h24);
        wait_p(20); lit("ones_27", 2'b01, 7'h78);
        wait_p(21); set_in(1'b1, 4'd5, 4'd5);
        wait_p(22); set_in(1'b0, 4'd0, 4'd0);
        wait_p(26); lit("tens_55", 2'b10, 7'h12);

        // Leading-zero blanking, then disabled
        lz_blank_en = 1'b1;
        wait_p(27); set_in(1'b1, 4'd0, 4'd9);
        wait_p(28); set_in(1'b0, 4'd0, 4'd0);
        wait_p(38); lit("lz_tens", 2'b11, 7'h7F);
        wait_p(44); lit("lz_ones", 2'b01, 7'h10);
        wait_p(45); lz_blank_en = 1'b0;
        wait_p(50); lit("nolz_tens", 2'b10, 7'h40);

        // Invalid digit raises err, a valid commit clears it
        wait_p(51); set_in(1'b1, 4'd1, 4'd12);
        wait_p(52); set_in(1'b0, 4'd0, 4'd0);
        wait_p(60); @(negedge clk); #1 chk("err_set", {7'd0, err_a}, 8'h01);
        wait_p(62); lit("inv_tens", 2'b10, 7'h79);
        wait_p(68); lit("inv_ones", 2'b01, 7'h06);
        wait_p(69); set_in(1'b1, 4'd3, 4'd4);
        wait_p(70); set_in(1'b0, 4'd0, 4'd0);
        wait_p(72); @(negedge clk); #1 chk("err_clr", {7'd0, err_a}, 8'h00);

        // Reset the no-blank instance during SHOW_O with a pair pending
        begin
            int n = 0;
            set_in(1'b1, 4'd6, 4'd8);
            while (!(phase_of(0, mp[1]) == 3 && mpend[1]) && n < 100) begin
                @(posedge clk); #1; n++;
            end
            chk("find_so_pending", {7'd0, (n < 100)}, 8'h01);
            set_in(1'b0, 4'd0, 4'd0);
            async_reset_check();
        end

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_val  = ($urandom_range(0, 9) < 3);
            in_tens = 4'($urandom_range(0, 15));
            in_ones = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) lz_blank_en = ~lz_blank_en;
            if ($urandom_range(0, 499) == 0) async_reset_check();
        end

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
Downstream consumer of the 5-bit binary-to-BCD converter's tens/ones digits. Captures a BCD digit pair through a valid/ready handshake and time-multiplexes it onto a 2-digit common-anode seven-segment display. A blanking gap between digits prevents ghosting. New values are committed only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
REFRESH_DIV, 1000, cycles each digit is lit (SHOW slot); must be >= 1.
BLANK_CYCLES, 8, dark cycles before each SHOW slot; 0 removes BLANK states.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
in_val  in  1  upstream digit pair valid.
in_rdy  out  1  block can accept a pair.
in_tens  in  4  BCD tens digit.
in_ones  in  4  BCD ones digit.
lz_blank_en  in  1  blank tens digit when it is 0.
an  out  2  digit anodes, active-low; [1]=tens, [0]=ones.
seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
err  out  1  committed pair contains a digit > 9.

Behaviour:
- Reset (async on rst_n low, held while low) sets: state=BLANK_T, cnt=0, disp_tens=disp_ones=0, shadow=0, pending=0, an=2'b11, seg=7'h7F, err=0. in_rdy=1 after reset.
- Handshake: in_rdy = !pending (combinational from a flop). On a clk edge with in_val && in_rdy, shadow <= {in_tens,in_ones} and pending <= 1. in_val while in_rdy=0 is ignored; the upstream holds its data.
- FSM states: BLANK_T -> SHOW_T -> BLANK_O -> SHOW_O -> BLANK_T.
  - BLANK states last BLANK_CYCLES cycles. SHOW states last REFRESH_DIV cycles.
  - cnt counts 0..len-1 in each state and resets to 0 on every transition.
  - If BLANK_CYCLES==0, the BLANK states are skipped: SHOW_T <-> SHOW_O.
- Frame = 2*(BLANK_CYCLES+REFRESH_DIV) cycles.
- Commit happens on the SHOW_O exit edge: if pending, disp <= shadow and pending <= 0. in_rdy returns the next cycle. Capture and commit cannot coincide because in_rdy=0 while pending.
- an and seg are registered and decoded from next-state, so they match the state register in every cycle.
  - BLANK states: an=11, seg=7F.
  - SHOW_T: an=10, seg=dec(disp_tens).
  - SHOW_O: an=01, seg=dec(disp_ones).
  - Leading-zero blanking: in SHOW_T with lz_blank_en=1 and disp_tens==0, drive an=11 and seg=7F. lz_blank_en is sampled live.
- Decode, active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Any digit 10..15 decodes to 'E'=06.
- err is registered. It updates at commit to (disp_tens>9 || disp_ones>9) of the new value, so a valid commit clears it.
- Counter width is $clog2(max(REFRESH_DIV,BLANK_CYCLES,2)). There is no overflow beyond len-1.
- Reset mid-frame aborts immediately to the reset values. A pending shadow value is discarded.

Decomposition:
- Shared package holds:
  - state enum (BLANK_T, SHOW_T, BLANK_O, SHOW_O);
  - SEG_OFF=7'h7F, AN_OFF=2'b11, SEG_E=7'h06;
  - digit pattern constants.
- Sub-module bcd_to_seg7: combinational 4-bit -> 7-bit active-low decoder, including 'E' for 10..15. Instantiate it once, muxing the digit in by next-state.

Test Plan:
(Use REFRESH_DIV=4, BLANK_CYCLES=2, so a frame is 12 cycles.)
1. Reset: assert rst_n=0 mid-cycle -> an=11, seg=7F, err=0, in_rdy=1 with no clock edge. Release -> first SHOW_T at cycle 2 shows seg=40, an=10.
2. Handshake: in_val=1, tens=2, ones=7 during SHOW_T -> in_rdy=0 next cycle. Display stays 0/0 until frame end. Next frame: SHOW_T an=10 seg=24, SHOW_O an=01 seg=78, each for 4 cycles, with 2-cycle an=11 gaps. in_rdy=1 the cycle after commit.
3. Back-pressure: a second pair (5,5) offered while pending -> not captured. Re-offered after in_rdy=1 -> shown one frame later.
4. Leading-zero: tens=0, ones=9, lz_blank_en=1 -> SHOW_T an=11 seg=7F, SHOW_O an=01 seg=10. With lz_blank_en=0 -> SHOW_T seg=40.
5. Invalid: tens=1, ones=12 -> after commit err=1, SHOW_O seg=06, SHOW_T seg=79. Next commit of (3,4) -> err=0.
6. BLANK_CYCLES=0 build: an alternates 10/01 every 4 cycles and never shows 11 except under lz blanking. Reset during SHOW_O with pending -> pending dropped, in_rdy=1.
